evt_stream_arbiter: RTL and testbench

Merges `NUM_INPUTS` independent event streams into one output stream. It sits directly upstream of the event FIFO (`evt_fifo`) and drives that FIFO's input stream. Arbitration is round-robin with a bounded burst lock, so a source keeps the grant for up to `MAX_BURST` consecutive events; this preserves short spike bursts from one source. The output is decoupled through a 2-entry skid buffer, giving full throughput with no combinational `out_ready_i` → `in_ready_o` path.

---
 rtl/evt_stream_arbiter.sv | 171 +++++++++++++++++
 tb/tb_evt_stream_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/evt_stream_arbiter.sv
// -----------------------------------------------------------------------------
// evt_stream_arbiter
//   Merges NUM_INPUTS event streams into one output stream feeding evt_fifo.
//   Round-robin arbitration with a burst lock: the current owner keeps the
//   grant for up to MAX_BURST consecutive accepted events, so short spike
//   bursts from one source stay together. The output goes through a 2-entry
//   skid buffer, so in_ready_o never depends on out_ready_i.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          synchronous clear (returns to reset state, refuses inputs)
//   in_evt_i       packed payloads, input i at [i*EVT_WIDTH +: EVT_WIDTH]
//   in_valid_i     per-input valid
//   in_ready_o     per-input ready, at most one bit set
//   out_evt_o      head of skid buffer (registered)
//   out_valid_o    skid buffer not empty (registered)
//   out_ready_i    downstream ready
//   grant_idx_o    index of the input whose event was last accepted
//   evt_cnt_o      number of output handshakes, wraps mod 2^32
// -----------------------------------------------------------------------------
module evt_stream_arbiter #(
   parameter int NUM_INPUTS = 4,
   parameter int EVT_WIDTH  = 32,
   parameter int MAX_BURST  = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            clr_i,
   input  logic [NUM_INPUTS*EVT_WIDTH-1:0] in_evt_i,
   input  logic [NUM_INPUTS-1:0]           in_valid_i,
   output logic [NUM_INPUTS-1:0]           in_ready_o,
   output logic [EVT_WIDTH-1:0]            out_evt_o,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [$clog2(NUM_INPUTS)-1:0]   grant_idx_o,
   output logic [31:0]                     evt_cnt_o
);

   localparam int IDX_W = $clog2(NUM_INPUTS);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   // arbitration state
   logic             r_locked;
   logic [IDX_W-1:0] r_owner;
   logic [BC_W-1:0]  r_bc;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_gidx;
   // skid buffer: r_buf0 is the head
   logic [EVT_WIDTH-1:0] r_buf0;
   logic [EVT_WIDTH-1:0] r_buf1;
   logic [1:0]           r_cnt;
   logic                 r_vld;
   logic [31:0]          r_evt_cnt;

   logic             w_gnt_vld;
   logic [IDX_W-1:0] w_gnt;
   logic             w_acc_ok;
   logic             w_push;
   logic             w_pop;
   logic             w_same;
   logic [BC_W-1:0]  w_bc_nxt;
   logic [IDX_W-1:0] w_rr_nxt;
   logic [1:0]       w_cnt_nxt;
   logic [EVT_WIDTH-1:0] w_din;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int k);
      int s;
      s = int'(a) + k;
      if (s >= NUM_INPUTS) s = s - NUM_INPUTS;
      return s[IDX_W-1:0];
   endfunction

   // Grant: locked owner wins while valid, otherwise first valid from rr_ptr.
   // The scan runs from the farthest offset down so the nearest one wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      if (r_locked && in_valid_i[r_owner]) begin
         w_gnt_vld = 1'b1;
         w_gnt     = r_owner;
      end else begin
         for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (in_valid_i[wrap_add(r_rr_ptr, k)]) begin
               w_gnt_vld = 1'b1;
               w_gnt     = wrap_add(r_rr_ptr, k);
            end
         end
      end
   end

   // Space is judged from registered r_cnt only: no out_ready_i -> in_ready_o path.
   assign w_acc_ok = (r_cnt != 2'd2) && !clr_i;
   assign w_push   = w_gnt_vld && w_acc_ok;
   assign w_pop    = r_vld && out_ready_i;
   assign w_din    = in_evt_i[int'(w_gnt)*EVT_WIDTH +: EVT_WIDTH];

   always_comb begin
      in_ready_o = '0;
      if (w_push) in_ready_o[w_gnt] = 1'b1;
   end

   assign w_same   = r_locked && (r_owner == w_gnt);
   assign w_bc_nxt = w_same ? (r_bc + 1'b1) : BC_W'(1);
   assign w_rr_nxt = (int'(w_gnt) == NUM_INPUTS - 1) ? '0 : (w_gnt + 1'b1);

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + 2'd1;
         2'b01:   w_cnt_nxt = r_cnt - 2'd1;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_locked  <= 1'b0;
         r_owner   <= '0;
         r_bc      <= '0;
         r_rr_ptr  <= '0;
         r_gidx    <= '0;
         r_buf0    <= '0;
         r_buf1    <= '0;
         r_cnt     <= 2'd0;
         r_vld     <= 1'b0;
         r_evt_cnt <= '0;
      end else if (clr_i) begin
         r_locked  <= 1'b0;
         r_owner   <= '0;
         r_bc      <= '0;
         r_rr_ptr  <= '0;
         r_gidx    <= '0;
         r_buf0    <= '0;
         r_buf1    <= '0;
         r_cnt     <= 2'd0;
         r_vld     <= 1'b0;
         r_evt_cnt <= '0;
      end else begin
         if (w_push) begin
            r_owner  <= w_gnt;
            r_bc     <= w_bc_nxt;
            r_locked <= (w_bc_nxt != BC_W'(MAX_BURST));
            r_rr_ptr <= w_rr_nxt;
            r_gidx   <= w_gnt;
         end else if (r_locked && !in_valid_i[r_owner]) begin
            // owner dropped valid: give up the lock, keep burst_cnt
            r_locked <= 1'b0;
         end

         if (w_pop) r_evt_cnt <= r_evt_cnt + 32'd1;

         // Push lands in the head when the buffer is (or becomes) empty,
         // otherwise in the second slot; a pop shifts slot 1 into the head.
         if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)))
            r_buf0 <= w_din;
         else if (w_pop)
            r_buf0 <= r_buf1;
         if (w_push && (r_cnt == 2'd1) && !w_pop)
            r_buf1 <= w_din;

         r_cnt <= w_cnt_nxt;
         r_vld <= (w_cnt_nxt != 2'd0);
      end
   end

   assign out_evt_o   = r_buf0;
   assign out_valid_o = r_vld;
   assign grant_idx_o = r_gidx;
   assign evt_cnt_o   = r_evt_cnt;

endmodule

// File: tb/tb_evt_stream_arbiter.sv
module tb_evt_stream_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int MB = 8;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           clr_i;
   logic [N*W-1:0] in_evt_i;
   logic [N-1:0]   in_valid_i;
   logic [N-1:0]   in_ready_o;
   logic [W-1:0]   out_evt_o;
   logic           out_valid_o;
   logic           out_ready_i;
   logic [1:0]     grant_idx_o;
   logic [31:0]    evt_cnt_o;

   evt_stream_arbiter #(.NUM_INPUTS(N), .EVT_WIDTH(W), .MAX_BURST(MB)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
      .in_evt_i(in_evt_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .out_evt_o(out_evt_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .grant_idx_o(grant_idx_o), .evt_cnt_o(evt_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int seq [N];
   logic [W-1:0] outq [$];
   logic [N-1:0] last_hs;
   logic [N-1:0] last_rdy;
   int idle;

   // payload: 4'hA, source index, 24-bit per-source sequence number
   function automatic logic [W-1:0] pay(input int i, input int s);
      return {4'hA, i[3:0], s[23:0]};
   endfunction

   always_comb begin
      in_evt_i = '0;
      for (int i = 0; i < N; i++) in_evt_i[i*W +: W] = pay(i, seq[i]);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // one clock: sample handshakes at the negedge, advance sources after the posedge
   task automatic step();
      @(negedge clk_i);
      last_rdy = in_ready_o;
      last_hs  = in_ready_o & in_valid_i;
      if (outq.size() > 0 && outq.size() < 5 && !out_valid_o) idle++;
      if (out_valid_o && out_ready_i) outq.push_back(out_evt_o);
      @(posedge clk_i); #1;
      for (int i = 0; i < N; i++) if (last_hs[i]) seq[i]++;
   endtask

   task automatic do_reset();
      in_valid_i  = '0;
      clr_i       = 1'b0;
      out_ready_i = 1'b0;
      rst_i       = 1'b1;
      for (int i = 0; i < N; i++) seq[i] = 0;
      outq.delete();
      idle = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   initial begin
      int acc;
      logic [N-1:0] rdy_or;
      in_valid_i = '0; clr_i = 1'b0; out_ready_i = 1'b0; rst_i = 1'b1;
      for (int i = 0; i < N; i++) seq[i] = 0;

      // reset state
      do_reset();
      chk("rst_valid", out_valid_o, 0);
      chk("rst_evt", out_evt_o, 0);
      chk("rst_cnt", evt_cnt_o, 0);
      chk("rst_gidx", grant_idx_o, 0);
      chk("rst_rdy", in_ready_o, 0);

      // burst lock: 8 from input 0, 8 from input 1, 8 from input 0
      in_valid_i = 4'b0011; out_ready_i = 1'b1; #1;
      chk("burst_first_rdy", in_ready_o, 4'b0001);
      for (int c = 0; c < 60 && outq.size() < 24; c++) step();
      chk("burst_n", outq.size(), 24);
      chk("burst_evt_cnt", evt_cnt_o, 24);
      for (int k = 0; k < 24 && k < outq.size(); k++)
         chk($sformatf("burst_ev%0d", k), outq[k], pay((k / 8) % 2, (k / 16) * 8 + k % 8));

      // lock release on drop: 2,2,2 then 3 with no idle output cycle
      do_reset();
      in_valid_i = 4'b1100; out_ready_i = 1'b1;
      for (int c = 0; c < 30 && outq.size() < 5; c++) begin
         step();
         if (seq[2] == 3 && in_valid_i[2]) begin
            in_valid_i[2] = 1'b0; #1;
            chk("drop_rdy", in_ready_o, 4'b1000);
         end
      end
      chk("drop_n", outq.size(), 5);
      chk("drop_idle", idle, 0);
      for (int k = 0; k < 5 && k < outq.size(); k++)
         chk($sformatf("drop_ev%0d", k), outq[k], (k < 3) ? pay(2, k) : pay(3, k - 3));

      // backpressure: exactly 2 absorbed, then ready all zero
      do_reset();
      in_valid_i = 4'b0001; out_ready_i = 1'b0;
      acc = 0; rdy_or = '0;
      for (int s = 0; s < 5; s++) begin
         step();
         acc += $countones(last_hs);
         if (s >= 2) rdy_or |= last_rdy;
      end
      chk("bp_accepted", acc, 2);
      chk("bp_rdy_zero", rdy_or, 0);
      chk("bp_valid", out_valid_o, 1);
      chk("bp_head", out_evt_o, pay(0, 0));
      out_ready_i = 1'b1;
      for (int c = 0; c < 30 && outq.size() < 6; c++) step();
      chk("bp_n", outq.size(), 6);
      for (int k = 0; k < 6 && k < outq.size(); k++)
         chk($sformatf("bp_ev%0d", k), outq[k], pay(0, k));

      // clear mid-burst with full buffer and input 1 locked
      do_reset();
      in_valid_i = 4'b0010; out_ready_i = 1'b1;
      repeat (3) step();
      out_ready_i = 1'b0;
      repeat (2) step();
      chk("clr_pre_cnt", evt_cnt_o, 2);
      chk("clr_pre_gidx", grant_idx_o, 1);
      in_valid_i = 4'b0011; clr_i = 1'b1; #1;
      chk("clr_rdy", in_ready_o, 0);
      step();
      clr_i = 1'b0; #1;
      chk("clr_valid", out_valid_o, 0);
      chk("clr_cnt", evt_cnt_o, 0);
      chk("clr_gidx", grant_idx_o, 0);
      chk("clr_restart", in_ready_o, 4'b0001);

      // asynchronous reset between clock edges
      do_reset();
      in_valid_i = 4'b1000; out_ready_i = 1'b1;
      repeat (4) step();
      chk("ar_pre_cnt", evt_cnt_o, 3);
      chk("ar_pre_gidx", grant_idx_o, 3);
      #2;
      in_valid_i = '0; rst_i = 1'b1; #1;
      chk("ar_valid", out_valid_o, 0);
      chk("ar_evt", out_evt_o, 0);
      chk("ar_cnt", evt_cnt_o, 0);
      chk("ar_gidx", grant_idx_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // counter wrap
      do_reset();
      @(negedge clk_i);
      force dut.r_evt_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_evt_cnt;
      in_valid_i = 4'b0001; out_ready_i = 1'b1;
      #1;
      chk("wrap_preload", evt_cnt_o, 32'hFFFF_FFFE);
      for (int c = 0; c < 20 && outq.size() < 3; c++) begin
         step();
         if (outq.size() == 2 && last_hs != 0 && seq[0] == 3)
            chk("wrap_zero", evt_cnt_o, 0);
      end
      chk("wrap_n", outq.size(), 3);
      chk("wrap_final", evt_cnt_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
